// File: rtl/regfile_operand_sequencer.sv
// rtl/regfile_operand_sequencer.sv - two-source operand fetch over a single registered read port
// Optional RF_ZERO_REG_EN: register 0 of every thread reads as zero and is never written.
module regfile_operand_sequencer #(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_req_valid,
  output logic                                    out_req_ready,
  input  logic [THREAD_INDEX_BITS-1:0]            in_req_tid,
  input  logic [REG_INDEX_BITS-1:0]               in_req_rs1,
  input  logic [REG_INDEX_BITS-1:0]               in_req_rs2,
  input  logic                                    in_wb_we,
  input  logic [THREAD_INDEX_BITS-1:0]            in_wb_tid,
  input  logic [REG_INDEX_BITS-1:0]               in_wb_rd,
  input  logic [DATA_WIDTH-1:0]                   in_wb_data,
  output logic [REG_INDEX_BITS+THREAD_INDEX_BITS-1:0] out_rf_raddr,
  output logic [REG_INDEX_BITS+THREAD_INDEX_BITS-1:0] out_rf_waddr,
  output logic [DATA_WIDTH-1:0]                   out_rf_wdata,
  output logic                                    out_rf_we,
  input  logic [DATA_WIDTH-1:0]                   in_rf_rdata,
  output logic                                    out_op_valid,
  input  logic                                    in_op_ready,
  output logic [THREAD_INDEX_BITS-1:0]            out_op_tid,
  output logic [DATA_WIDTH-1:0]                   out_op_a,
  output logic [DATA_WIDTH-1:0]                   out_op_b
);

  localparam int AW = REG_INDEX_BITS + THREAD_INDEX_BITS;

  typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, CAPTURE_B, VALID} state_t;

  state_t                         state_q, state_d;
  logic [THREAD_INDEX_BITS-1:0]   tid_q, tid_d;
  logic [REG_INDEX_BITS-1:0]      rs1_q, rs1_d;
  logic [REG_INDEX_BITS-1:0]      rs2_q, rs2_d;
  logic                           fwd_a_q, fwd_a_d;
  logic                           fwd_b_q, fwd_b_d;
  logic [DATA_WIDTH-1:0]          fwd_a_data_q, fwd_a_data_d;
  logic [DATA_WIDTH-1:0]          fwd_b_data_q, fwd_b_data_d;
  logic                           op_valid_q, op_valid_d;
  logic [THREAD_INDEX_BITS-1:0]   op_tid_q, op_tid_d;
  logic [DATA_WIDTH-1:0]          op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]          op_b_q, op_b_d;

  logic [AW-1:0] addr_a, addr_b, wb_addr;
  logic          zero_a, zero_b, wb_zero;
  logic          hit_a, hit_b, accept;

  assign addr_a  = {tid_q, rs1_q};
  assign addr_b  = {tid_q, rs2_q};
  assign wb_addr = {in_wb_tid, in_wb_rd};

`ifdef RF_ZERO_REG_EN
  assign zero_a  = (rs1_q == '0);
  assign zero_b  = (rs2_q == '0);
  assign wb_zero = (in_wb_rd == '0);
`else
  assign zero_a  = 1'b0;
  assign zero_b  = 1'b0;
  assign wb_zero = 1'b0;
`endif

  assign hit_a = in_wb_we && (wb_addr == addr_a) && !zero_a;
  assign hit_b = in_wb_we && (wb_addr == addr_b) && !zero_b;

  assign out_req_ready = (state_q == IDLE) || ((state_q == VALID) && in_op_ready);
  assign accept        = in_req_valid && out_req_ready;

  assign out_rf_raddr = (state_q == ISSUE_B || state_q == CAPTURE_B) ? addr_b : addr_a;
  assign out_rf_waddr = wb_addr;
  assign out_rf_wdata = in_wb_data;
  assign out_rf_we    = rst_n && in_wb_we && !wb_zero;

  assign out_op_valid = op_valid_q;
  assign out_op_tid   = op_tid_q;
  assign out_op_a     = op_a_q;
  assign out_op_b     = op_b_q;

  always_comb begin
    state_d      = state_q;
    tid_d        = tid_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;
    fwd_a_data_d = fwd_a_data_q;
    fwd_b_data_d = fwd_b_data_q;
    op_valid_d   = op_valid_q;
    op_tid_d     = op_tid_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tid_d   = in_req_tid;
          rs1_d   = in_req_rs1;
          rs2_d   = in_req_rs2;
          state_d = ISSUE_A;
        end
      end
      ISSUE_A: begin
        // A write landing with the read returns stale data, so remember it.
        fwd_a_d      = hit_a;
        fwd_a_data_d = in_wb_data;
        fwd_b_d      = 1'b0;
        state_d      = ISSUE_B;
      end
      ISSUE_B: begin
        if (zero_a)       op_a_d = '0;
        else if (hit_a)   op_a_d = in_wb_data;
        else if (fwd_a_q) op_a_d = fwd_a_data_q;
        else              op_a_d = in_rf_rdata;
        fwd_b_d      = hit_b;
        fwd_b_data_d = in_wb_data;
        op_tid_d     = tid_q;
        state_d      = CAPTURE_B;
      end
      CAPTURE_B: begin
        if (zero_b)       op_b_d = '0;
        else if (hit_b)   op_b_d = in_wb_data;
        else if (fwd_b_q) op_b_d = fwd_b_data_q;
        else              op_b_d = in_rf_rdata;
        if (hit_a) op_a_d = in_wb_data;
        op_valid_d = 1'b1;
        state_d    = VALID;
      end
      VALID: begin
        if (hit_a) op_a_d = in_wb_data;
        if (hit_b) op_b_d = in_wb_data;
        if (in_op_ready) begin
          op_valid_d = 1'b0;
          if (in_req_valid) begin
            tid_d   = in_req_tid;
            rs1_d   = in_req_rs1;
            rs2_d   = in_req_rs2;
            state_d = ISSUE_A;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tid_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      fwd_a_q      <= 1'b0;
      fwd_b_q      <= 1'b0;
      fwd_a_data_q <= '0;
      fwd_b_data_q <= '0;
      op_valid_q   <= 1'b0;
      op_tid_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      tid_q        <= tid_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      fwd_a_data_q <= fwd_a_data_d;
      fwd_b_data_q <= fwd_b_data_d;
      op_valid_q   <= op_valid_d;
      op_tid_q     <= op_tid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

endmodule

// File: tb/tb_regfile_operand_sequencer.sv
// tb/tb_regfile_operand_sequencer.sv - directed bench with a registered-read register file model
module tb_regfile_operand_sequencer;

  localparam int DW = 64;
  localparam int RB = 5;
  localparam int TB = 3;
  localparam int AW = RB + TB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_req_valid;
  logic          out_req_ready;
  logic [TB-1:0] in_req_tid;
  logic [RB-1:0] in_req_rs1, in_req_rs2;
  logic          in_wb_we;
  logic [TB-1:0] in_wb_tid;
  logic [RB-1:0] in_wb_rd;
  logic [DW-1:0] in_wb_data;
  logic [AW-1:0] out_rf_raddr, out_rf_waddr;
  logic [DW-1:0] out_rf_wdata;
  logic          out_rf_we;
  logic [DW-1:0] in_rf_rdata;
  logic          out_op_valid;
  logic          in_op_ready;
  logic [TB-1:0] out_op_tid;
  logic [DW-1:0] out_op_a, out_op_b;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  regfile_operand_sequencer #(.DATA_WIDTH(DW), .REG_INDEX_BITS(RB), .THREAD_INDEX_BITS(TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
    .in_req_tid(in_req_tid), .in_req_rs1(in_req_rs1), .in_req_rs2(in_req_rs2),
    .in_wb_we(in_wb_we), .in_wb_tid(in_wb_tid), .in_wb_rd(in_wb_rd), .in_wb_data(in_wb_data),
    .out_rf_raddr(out_rf_raddr), .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
    .out_rf_we(out_rf_we), .in_rf_rdata(in_rf_rdata),
    .out_op_valid(out_op_valid), .in_op_ready(in_op_ready), .out_op_tid(out_op_tid),
    .out_op_a(out_op_a), .out_op_b(out_op_b)
  );

  always #5 clk = ~clk;

  // Register file: read data registered one cycle after the address; a same-edge write is not visible.
  always @(posedge clk) begin
    in_rf_rdata <= mem[out_rf_raddr];
    if (out_rf_we) mem[out_rf_waddr] <= out_rf_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_drive(input logic [TB-1:0] t, input logic [RB-1:0] r, input logic [DW-1:0] d);
    in_wb_we = 1'b1; in_wb_tid = t; in_wb_rd = r; in_wb_data = d;
  endtask

  task automatic wb_write(input logic [TB-1:0] t, input logic [RB-1:0] r, input logic [DW-1:0] d);
    wb_drive(t, r, d);
    step();
    in_wb_we = 1'b0;
  endtask

  task automatic issue(input logic [TB-1:0] t, input logic [RB-1:0] a, input logic [RB-1:0] b);
    in_req_valid = 1'b1; in_req_tid = t; in_req_rs1 = a; in_req_rs2 = b;
    step();
    in_req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_op_valid && n < 10) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    in_op_ready = 1'b1;
    step();
    in_op_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_wb_we = 1'b1; in_wb_tid = 3'd1; in_wb_rd = 5'd3; in_wb_data = 64'hDEAD;
    step(); step();
    checks++; if (out_rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", out_rf_we); end
    checks++; if (out_op_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_op_valid); end
    checks++; if ({out_op_a, out_op_b, out_op_tid} !== '0) begin errors++; $display("FAIL reset_ops: got a=%h b=%h tid=%h expected 0", out_op_a, out_op_b, out_op_tid); end
    checks++; if (out_rf_raddr !== '0) begin errors++; $display("FAIL reset_raddr: got %h expected 0", out_rf_raddr); end
    checks++; if (out_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", out_req_ready); end
    in_wb_we = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int n;
    wb_write(3'd2, 5'd5, 64'hAAAA_AAAA_AAAA_AAAA);
    wb_write(3'd2, 5'd6, 64'h1234);
    in_req_valid = 1'b1; in_req_tid = 3'd2; in_req_rs1 = 5'd5; in_req_rs2 = 5'd6;
    #1;
    checks++; if (out_req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %b expected 1", out_req_ready); end
    step();
    in_req_valid = 1'b0;
    checks++; if (out_rf_raddr !== 8'h45) begin errors++; $display("FAIL basic_raddr_a: got %h expected 45", out_rf_raddr); end
    wait_valid(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", n); end
    checks++; if (out_op_a !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL basic_a: got %h expected aaaaaaaaaaaaaaaa", out_op_a); end
    checks++; if (out_op_b !== 64'h1234) begin errors++; $display("FAIL basic_b: got %h expected 1234", out_op_b); end
    checks++; if (out_op_tid !== 3'd2) begin errors++; $display("FAIL basic_tid: got %0d expected 2", out_op_tid); end
    checks++; if (out_req_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_stall: got %b expected 0", out_req_ready); end
    handshake();
    checks++; if (out_op_valid !== 1'b0 || out_req_ready !== 1'b1) begin errors++; $display("FAIL basic_after_hs: got valid=%b ready=%b expected 0 1", out_op_valid, out_req_ready); end
  endtask

  task automatic test_forward();
    int n;
    // Write to rs1 during its read cycle.
    issue(3'd2, 5'd5, 5'd6);
    wb_write(3'd2, 5'd5, 64'h55);
    wait_valid(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL fwd_issue_latency: got %0d expected 2", n); end
    checks++; if (out_op_a !== 64'h55 || out_op_b !== 64'h1234) begin errors++; $display("FAIL fwd_issue_a: got a=%h b=%h expected 55 1234", out_op_a, out_op_b); end
    handshake();
    // Issue-cycle forward then a capture-cycle write; the later one wins.
    issue(3'd2, 5'd5, 5'd6);
    wb_write(3'd2, 5'd5, 64'h11);
    wb_write(3'd2, 5'd5, 64'h22);
    wait_valid(n);
    checks++; if (out_op_a !== 64'h22) begin errors++; $display("FAIL fwd_capture_a: got %h expected 22", out_op_a); end
    handshake();
    // Write to rs2 during its read cycle.
    issue(3'd2, 5'd5, 5'd6);
    step();
    wb_write(3'd2, 5'd6, 64'h4321);
    wait_valid(n);
    checks++; if (out_op_b !== 64'h4321 || out_op_a !== 64'h22) begin errors++; $display("FAIL fwd_issue_b: got a=%h b=%h expected 22 4321", out_op_a, out_op_b); end
    handshake();
  endtask

  task automatic test_stall();
    int n;
    wb_write(3'd2, 5'd5, 64'hAAAA_AAAA_AAAA_AAAA);
    wb_write(3'd2, 5'd6, 64'h1234);
    issue(3'd2, 5'd5, 5'd6);
    wait_valid(n);
    step();
    wb_write(3'd2, 5'd6, 64'h99);
    checks++; if (out_op_b !== 64'h99 || out_op_a !== 64'hAAAA_AAAA_AAAA_AAAA || out_op_valid !== 1'b1) begin errors++; $display("FAIL stall_update: got a=%h b=%h valid=%b expected aaaaaaaaaaaaaaaa 99 1", out_op_a, out_op_b, out_op_valid); end
    wb_write(3'd3, 5'd6, 64'h77);
    checks++; if (out_op_b !== 64'h99 || out_op_valid !== 1'b1) begin errors++; $display("FAIL stall_other_tid: got b=%h valid=%b expected 99 1", out_op_b, out_op_valid); end
    step();
    in_op_ready = 1'b1;
    #1;
    checks++; if (out_req_ready !== 1'b1) begin errors++; $display("FAIL stall_hs_ready: got %b expected 1", out_req_ready); end
    step();
    in_op_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nv;
    logic exp_v;
    nv = 0;
    in_req_valid = 1'b1; in_req_tid = 3'd2; in_req_rs1 = 5'd5; in_req_rs2 = 5'd6;
    in_op_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_v = (i % 4 == 3);
      if (out_op_valid) nv++;
      checks++; if (out_op_valid !== exp_v || out_req_ready !== exp_v) begin errors++; $display("FAIL b2b_cycle%0d: got valid=%b ready=%b expected %b", i, out_op_valid, out_req_ready, exp_v); end
    end
    checks++; if (out_op_a !== 64'hAAAA_AAAA_AAAA_AAAA || out_op_b !== 64'h99) begin errors++; $display("FAIL b2b_data: got a=%h b=%h expected aaaaaaaaaaaaaaaa 99", out_op_a, out_op_b); end
    in_req_valid = 1'b0;
    step();
    in_op_ready = 1'b0;
    checks++; if (nv !== 3 || out_op_valid !== 1'b0) begin errors++; $display("FAIL b2b_count: got pulses=%0d valid=%b expected 3 0", nv, out_op_valid); end
  endtask

  task automatic test_reset_mid();
    int nv;
    nv = 0;
    issue(3'd2, 5'd5, 5'd6);
    step();
    checks++; if (out_rf_raddr !== 8'h46) begin errors++; $display("FAIL mid_raddr_b: got %h expected 46", out_rf_raddr); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_op_valid !== 1'b0 || out_rf_raddr !== '0) begin errors++; $display("FAIL mid_reset: got valid=%b raddr=%h expected 0 0", out_op_valid, out_rf_raddr); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (out_req_ready !== 1'b1 || out_rf_raddr !== '0) begin errors++; $display("FAIL mid_release: got ready=%b raddr=%h expected 1 0", out_req_ready, out_rf_raddr); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_op_valid) nv++;
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL mid_abandon: got %0d valid cycles expected 0", nv); end
  endtask

  task automatic test_zero_reg();
    int n;
    logic exp_we;
    logic [DW-1:0] exp_d;
`ifdef RF_ZERO_REG_EN
    exp_we = 1'b0; exp_d = 64'h0;
`else
    exp_we = 1'b1; exp_d = 64'hFF;
`endif
    wb_drive(3'd1, 5'd0, 64'hFF);
    #1;
    checks++; if (out_rf_we !== exp_we) begin errors++; $display("FAIL zero_we: got %b expected %b", out_rf_we, exp_we); end
    checks++; if (out_rf_waddr !== 8'h20 || out_rf_wdata !== 64'hFF) begin errors++; $display("FAIL zero_waddr: got %h/%h expected 20/ff", out_rf_waddr, out_rf_wdata); end
    step();
    in_wb_we = 1'b0;
    issue(3'd1, 5'd0, 5'd0);
    wait_valid(n);
    checks++; if (out_op_a !== exp_d || out_op_b !== exp_d || out_op_tid !== 3'd1) begin errors++; $display("FAIL zero_ops: got a=%h b=%h tid=%0d expected %h %h 1", out_op_a, out_op_b, out_op_tid, exp_d, exp_d); end
    handshake();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    in_req_valid = 1'b0; in_req_tid = '0; in_req_rs1 = '0; in_req_rs2 = '0;
    in_wb_we = 1'b0; in_wb_tid = '0; in_wb_rd = '0; in_wb_data = '0;
    in_op_ready = 1'b0;
    test_reset();
    test_basic();
    test_forward();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_zero_reg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_operand_sequencer.md
Name: regfile_operand_sequencer

Overview:
Operand-fetch controller for the multithreaded register file. The register file has one read port, one write port and a registered 1-cycle read. This block accepts a two-source operand request (thread, rs1, rs2) and issues both reads back-to-back on the single read port. It forwards write-back traffic to the write port, keeps fetched operands coherent against in-flight writes, and delivers both operands on a valid/ready interface to the execute stage.

Parameters:
DATA_WIDTH, 64, operand and register width
REG_INDEX_BITS, 5, register index width per thread
THREAD_INDEX_BITS, 3, thread id width; register file address = {tid, reg}, tid in MSBs

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
in_req_valid  in  1  operand request valid
out_req_ready  out  1  request accepted when valid & ready
in_req_tid  in  THREAD_INDEX_BITS  requesting thread
in_req_rs1  in  REG_INDEX_BITS  source A index
in_req_rs2  in  REG_INDEX_BITS  source B index
in_wb_we  in  1  write-back enable
in_wb_tid  in  THREAD_INDEX_BITS  write-back thread
in_wb_rd  in  REG_INDEX_BITS  write-back register
in_wb_data  in  DATA_WIDTH  write-back data
out_rf_raddr  out  REG_INDEX_BITS+THREAD_INDEX_BITS  register file read address
out_rf_waddr  out  REG_INDEX_BITS+THREAD_INDEX_BITS  register file write address = {in_wb_tid, in_wb_rd}
out_rf_wdata  out  DATA_WIDTH  = in_wb_data
out_rf_we  out  1  = in_wb_we, forced 0 while rst_n low
in_rf_rdata  in  DATA_WIDTH  register file read data, 1 cycle after raddr
out_op_valid  out  1  operands valid
in_op_ready  in  1  consumer accepts operands
out_op_tid  out  THREAD_INDEX_BITS  thread of delivered operands
out_op_a  out  DATA_WIDTH  value of rs1
out_op_b  out  DATA_WIDTH  value of rs2

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - out_op_valid=0; out_op_a/out_op_b/out_op_tid=0.
  - Latched tid/rs1/rs2=0, so out_rf_raddr=0.
  - Forward flags cleared.
- FSM states: IDLE, ISSUE_A, ISSUE_B, CAPTURE_B, VALID.
- IDLE: out_req_ready=1. On accept, latch tid/rs1/rs2 and go to ISSUE_A.
- ISSUE_A: out_rf_raddr={tid,rs1}. Go to ISSUE_B.
- ISSUE_B: out_rf_raddr={tid,rs2}. Capture in_rf_rdata into out_op_a. Go to CAPTURE_B.
- CAPTURE_B: out_rf_raddr={tid,rs2}. Capture in_rf_rdata into out_op_b. Go to VALID.
- VALID: out_op_valid=1; operands and tid held stable.
  - If in_op_ready=0: stay in VALID.
  - If in_op_ready=1 and in_req_valid=0: go to IDLE.
  - If in_op_ready=1 and in_req_valid=1: out_req_ready=1 in this same cycle; the new request is latched and the FSM goes to ISSUE_A.
- Latency: accept edge at cycle 0 gives out_op_valid high in cycle 3. Sustained throughput is 1 request per 4 cycles.
- out_req_ready is 1 only in IDLE, or in VALID with in_op_ready=1.
- Coherence: each operand reflects every write to its address from its issue cycle up to and including the handshake cycle. The latest write wins.
  - Issue-cycle collision: the register file returns old data when a write to the same address occurs in the read cycle. The block records a forward flag plus in_wb_data and uses it instead of in_rf_rdata at capture.
  - Write matching in the capture cycle: overrides both in_rf_rdata and any pending forward.
  - Write matching while in VALID: updates the held operand at the next edge, including in the handshake cycle. out_op_valid stays high.
  - rs1==rs2: both operands receive identical updates.
  - Writes to other threads or registers: no effect.
- Reset mid-operation: in-flight request abandoned; no operands delivered.

Optional Feature:
RF_ZERO_REG_EN
- Defined:
  - Register index 0 of every thread reads as 0. The operand is forced to 0 at capture and excluded from forwarding.
  - out_rf_we is forced 0 when in_wb_rd==0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Preload tid2 r5=0xAAAA_AAAA_AAAA_AAAA, r6=0x1234; request tid2 rs1=5 rs2=6 -> out_op_valid in cycle 3 after accept; a=0xAAAA_AAAA_AAAA_AAAA, b=0x1234, tid=2.
- Same request; write tid2 r5=0x55 in the ISSUE_A cycle -> a=0x55, not the stale register file value.
- in_op_ready low 5 cycles in VALID; write tid2 r6=0x99 in cycle 2 of the stall -> b=0x99, a unchanged, valid stays high. Write tid3 r6=0x77 -> no change.
- in_req_valid held high, in_op_ready=1 -> second request accepted in the handshake cycle; out_op_valid pulses every 4 cycles.
- Deassert rst_n during ISSUE_B -> out_op_valid=0 immediately; after release out_req_ready=1 and out_rf_raddr=0.
- With RF_ZERO_REG_EN: write tid1 r0=0xFF -> out_rf_we=0. Request tid1 rs1=0 rs2=0 -> a=0, b=0. Without the macro: out_rf_we=1, and a=b=0xFF.
